// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and defaults for the board-level soc clock stepper.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEP     = 2'd1,
    WAIT_REL = 2'd2,
    RUN      = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int BURST_CYCLES_DEF    = 100;
  localparam int CNT_W_DEF           = 32;

  // Width of the remaining-enables counter: must hold BURST_CYCLES itself.
  function automatic int rem_width(input int burst_cycles);
    if (burst_cycles < 1) begin
      return 1;
    end else begin
      return $clog2(burst_cycles + 1);
    end
  endfunction

endpackage

// File: rtl/stepper_debounce.sv
// stepper_debounce: 2-flop synchronizer followed by a stability-counter debouncer.
// The debounced output only follows the synchronized input once the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module stepper_debounce
  import stepper_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          deb_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous raw input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {RESET_VAL, RESET_VAL};
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  // Accept a new level only after it has been stable for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= RESET_VAL;
      cnt_r <= '0;
    end else if (sync_r[1] != deb_r) begin
      if (cnt_r == CNT_LAST) begin
        deb_r <= sync_r[1];
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign deb = deb_r;

endmodule

// File: rtl/soc_stepper.sv
// soc_stepper: turns a step pushbutton and a run switch into a qualified
// clock-enable for the soc, plus a count of issued enables.
// Optional feature macro: STEPPER_BURST_EN (adds key_burst_n, BURST_CYCLES enables per press).
module soc_stepper
  import stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BURST_CYCLES    = BURST_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_step_n,
  input  logic             sw_run,
`ifdef STEPPER_BURST_EN
  input  logic             key_burst_n,
`endif
  output logic             soc_clk_en,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int REM_W = rem_width(BURST_CYCLES);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [REM_W-1:0] REM_BURST = REM_W'(BURST_CYCLES);

  logic key_deb_s;
  logic run_deb_s;
  logic burst_deb_s;

  stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_key (
    .clk(clk), .rst_n(rst_n), .raw(key_step_n), .deb(key_deb_s)
  );

  stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .raw(sw_run), .deb(run_deb_s)
  );

`ifdef STEPPER_BURST_EN
  stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_burst (
    .clk(clk), .rst_n(rst_n), .raw(key_burst_n), .deb(burst_deb_s)
  );
`else
  // Without the burst key, behave as if it is permanently released.
  assign burst_deb_s = 1'b1;
`endif

  logic              key_prev_r;
  logic              burst_prev_r;
  logic              press_s;
  logic              burst_press_s;
  state_e            state_r;
  state_e            state_next_s;
  logic [REM_W-1:0]  rem_r;
  logic [REM_W-1:0]  rem_next_s;
  logic              en_next_s;
  logic              busy_next_s;
  logic              en_r;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r;

  // Remember the previous debounced key levels for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_r   <= 1'b1;
      burst_prev_r <= 1'b1;
    end else begin
      key_prev_r   <= key_deb_s;
      burst_prev_r <= burst_deb_s;
    end
  end

  assign press_s       = key_prev_r & ~key_deb_s;
  assign burst_press_s = burst_prev_r & ~burst_deb_s;

  // Next-state, remaining count and Moore output decode.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (run_deb_s) begin
          state_next_s = RUN;
        end else if (burst_press_s) begin
          state_next_s = STEP;
          rem_next_s   = REM_BURST;
        end else if (press_s) begin
          state_next_s = STEP;
          rem_next_s   = REM_ONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      STEP: begin
        if (rem_r == REM_ONE) begin
          state_next_s = WAIT_REL;
          rem_next_s   = '0;
        end else begin
          rem_next_s   = rem_r - REM_ONE;
        end
      end
      WAIT_REL: begin
        if (key_deb_s && burst_deb_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_REL;
        end
      end
      RUN: begin
        if (!run_deb_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
        rem_next_s   = '0;
      end
    endcase
    en_next_s   = (state_next_s == STEP) || (state_next_s == RUN);
    busy_next_s = (state_next_s != IDLE);
  end

  // State register with outputs registered alongside so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rem_r   <= '0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      rem_r   <= rem_next_s;
      en_r    <= en_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // Count issued enables; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (en_r) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign soc_clk_en  = en_r;
  assign busy        = busy_r;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_soc_stepper.sv
// tb_soc_stepper: directed self-checking bench for soc_stepper
// (DEBOUNCE_CYCLES=4, BURST_CYCLES=5, CNT_W=4 so the count wrap is reachable).
module tb_soc_stepper;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             key_step_n;
  logic             sw_run;
`ifdef STEPPER_BURST_EN
  logic             key_burst_n;
`endif
  logic             soc_clk_en;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;

  int checks;
  int errors;
  int en_cycles;
  int en_edges;
  logic prev_en;
  int exp_count;
  logic [CNT_W-1:0] exp_cnt_v;

  soc_stepper #(.DEBOUNCE_CYCLES(4), .BURST_CYCLES(5), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_step_n(key_step_n),
    .sw_run(sw_run),
`ifdef STEPPER_BURST_EN
    .key_burst_n(key_burst_n),
`endif
    .soc_clk_en(soc_clk_en),
    .busy(busy),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, sampling 1 ns after each rising edge and tallying enables.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (soc_clk_en === 1'b1) begin
        en_cycles++;
        if (prev_en !== 1'b1) en_edges++;
      end
      prev_en = soc_clk_en;
    end
  endtask

  task automatic clear_counts();
    en_cycles = 0;
    en_edges  = 0;
    prev_en   = soc_clk_en;
  endtask

  task automatic check_count(input string name);
    exp_cnt_v = exp_count[CNT_W-1:0];
    checks++;
    if (cycle_count !== exp_cnt_v) begin
      errors++;
      $display("FAIL %s: cycle_count got %0d expected %0d", name, cycle_count, exp_cnt_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_step_n = 1'b0; sw_run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (soc_clk_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", soc_clk_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    exp_count = 0;
    check_count("reset_count");
    rst_n = 1'b1;
    clear_counts();
    cycles(30);
    checks++;
    if (en_cycles !== 1) begin errors++; $display("FAIL reset_held_key_enables: got %0d expected 1", en_cycles); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_held_key_busy: got %b expected 1", busy); end
    key_step_n = 1'b1;
    cycles(15);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    exp_count = 1;
    check_count("reset_after_step");
  endtask

  task automatic test_single_step();
    clear_counts();
    key_step_n = 1'b0;
    cycles(20);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL step_busy_held: got %b expected 1", busy); end
    key_step_n = 1'b1;
    cycles(15);
    checks++;
    if (en_cycles !== 1) begin errors++; $display("FAIL step_enables: got %0d expected 1", en_cycles); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL step_busy_released: got %b expected 0", busy); end
    exp_count = 2;
    check_count("step_count");
  endtask

  task automatic test_glitch();
    clear_counts();
    key_step_n = 1'b0;
    cycles(3);
    key_step_n = 1'b1;
    cycles(20);
    checks++;
    if (en_cycles !== 0) begin errors++; $display("FAIL glitch_enables: got %0d expected 0", en_cycles); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    check_count("glitch_count");
  endtask

  task automatic test_run();
    clear_counts();
    sw_run = 1'b1;
    cycles(30);
    checks++;
    if (soc_clk_en !== 1'b1) begin errors++; $display("FAIL run_en_high: got %b expected 1", soc_clk_en); end
    sw_run = 1'b0;
    cycles(20);
    checks++;
    if (en_cycles !== 30) begin errors++; $display("FAIL run_enables: got %0d expected 30", en_cycles); end
    checks++;
    if (en_edges !== 1) begin errors++; $display("FAIL run_contiguous: got %0d expected 1", en_edges); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_idle: got %b expected 0", busy); end
    exp_count = exp_count + 30;
    check_count("run_count_wrap");
  endtask

  task automatic test_priority();
    clear_counts();
    key_step_n = 1'b0;
    sw_run = 1'b1;
    cycles(30);
    sw_run = 1'b0;
    cycles(20);
    key_step_n = 1'b1;
    cycles(15);
    checks++;
    if (en_cycles !== 30) begin errors++; $display("FAIL prio_enables: got %0d expected 30", en_cycles); end
    checks++;
    if (en_edges !== 1) begin errors++; $display("FAIL prio_no_extra_step: got %0d expected 1", en_edges); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b expected 0", busy); end
    exp_count = exp_count + 30;
    check_count("prio_count");
  endtask

`ifdef STEPPER_BURST_EN
  task automatic wait_en(input string name);
    int budget;
    budget = 40;
    while ((en_cycles == 0) && (budget > 0)) begin
      cycles(1);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no enable expected one within 40 cycles", name);
    end
  endtask

  task automatic test_burst();
    clear_counts();
    key_burst_n = 1'b0;
    cycles(20);
    key_burst_n = 1'b1;
    cycles(15);
    checks++;
    if (en_cycles !== 5) begin errors++; $display("FAIL burst_enables: got %0d expected 5", en_cycles); end
    checks++;
    if (en_edges !== 1) begin errors++; $display("FAIL burst_contiguous: got %0d expected 1", en_edges); end
    exp_count = exp_count + 5;
    check_count("burst_count");
  endtask

  task automatic test_burst_run_ignored();
    clear_counts();
    key_burst_n = 1'b0;
    wait_en("burst_run");
    sw_run = 1'b1;
    cycles(20);
    checks++;
    if (en_cycles !== 5) begin errors++; $display("FAIL burst_run_not_extended: got %0d expected 5", en_cycles); end
    sw_run = 1'b0;
    cycles(15);
    key_burst_n = 1'b1;
    cycles(15);
    checks++;
    if (en_edges !== 1) begin errors++; $display("FAIL burst_run_edges: got %0d expected 1", en_edges); end
    exp_count = exp_count + 5;
    check_count("burst_run_count");
  endtask

  task automatic test_back_to_back();
    clear_counts();
    key_step_n = 1'b0;
    key_burst_n = 1'b0;
    cycles(20);
    key_step_n = 1'b1;
    key_burst_n = 1'b1;
    cycles(15);
    checks++;
    if (en_cycles !== 5) begin errors++; $display("FAIL simul_press_burst: got %0d expected 5", en_cycles); end
    exp_count = exp_count + 5;
    check_count("simul_count");
  endtask

  task automatic test_reset_abort();
    clear_counts();
    key_burst_n = 1'b0;
    wait_en("abort");
    cycles(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (soc_clk_en !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", soc_clk_en); end
    key_burst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_counts();
    cycles(20);
    checks++;
    if (en_cycles !== 0) begin errors++; $display("FAIL abort_residual: got %0d expected 0", en_cycles); end
    exp_count = 0;
    check_count("abort_count");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    rst_n = 1'b0;
    key_step_n = 1'b1;
    sw_run = 1'b0;
`ifdef STEPPER_BURST_EN
    key_burst_n = 1'b1;
`endif
    prev_en = 1'b0;
    en_cycles = 0;
    en_edges = 0;
    test_reset();
    test_single_step();
    test_glitch();
    test_run();
    test_priority();
`ifdef STEPPER_BURST_EN
    test_burst();
    test_burst_run_ignored();
    test_back_to_back();
    test_reset_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
